picorv32_pcpi_vec: RTL and testbench

PICORV32_PCPI_VEC -- requirements
Module: picorv32_pcpi_vec

---
 rtl/picorv32_pcpi_vec_pkg.sv | 28 ++
 rtl/pcpi_vec_regfile.sv | 32 +++
 rtl/picorv32_pcpi_vec.sv | 196 +++++++++++++++++++
 tb/tb_picorv32_pcpi_vec.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/picorv32_pcpi_vec_pkg.sv
// Shared decode constants, FSM states and SEW encoding for the PCPI vector unit.
// No logic: latency and backpressure are defined by the modules that import this.
package picorv32_pcpi_vec_pkg;
    localparam int VLEN_DEF = 128;
    localparam int NREG_DEF = 32;

    localparam logic [6:0] OPC_OPV      = 7'b1010111;
    localparam logic [6:0] OPC_CUST     = 7'b1011011;
    localparam logic [2:0] F3_VEC       = 3'b111;
    localparam logic [6:0] F7_VSETVAP   = 7'b1000000;
    localparam logic [5:0] F6_VLES_VARP = 6'b000001;

    typedef enum logic [2:0] {
        ST_IDLE, ST_EXEC, ST_LOAD_REQ, ST_LOAD_WAIT, ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        SEW_E8 = 2'd0, SEW_E16 = 2'd1, SEW_E32 = 2'd2
    } sew_e;

    typedef enum logic [1:0] {
        OP_VSETVLI, OP_VSETVAP, OP_VLES
    } op_e;

    function automatic logic [5:0] sew_bits(input sew_e s);
        return 6'd8 << s;
    endfunction
endpackage

// File: rtl/pcpi_vec_regfile.sv
// NREG x VLEN vector storage with one SEW-wide element write port, written on the clock edge.
// Always accepts a write; no backpressure. Caller guarantees the element index is in range.
module pcpi_vec_regfile
    import picorv32_pcpi_vec_pkg::*;
#(
    parameter int VLEN = VLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int RW   = $clog2(NREG),
    parameter int IW   = $clog2(VLEN/8)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          i_we,
    input  logic [RW-1:0] i_reg,
    input  logic [IW-1:0] i_idx,
    input  sew_e          i_sew,
    input  logic [31:0]   i_data
);
    logic [VLEN-1:0] r_mem [NREG];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < NREG; k++) r_mem[k] <= '0;
        end else if (i_we) begin
            case (i_sew)
                SEW_E8:  r_mem[i_reg][i_idx*8  +: 8]  <= i_data[7:0];
                SEW_E16: r_mem[i_reg][i_idx*16 +: 16] <= i_data[15:0];
                default: r_mem[i_reg][i_idx*32 +: 32] <= i_data;
            endcase
        end
    end
endmodule

// File: rtl/picorv32_pcpi_vec.sv
// PCPI vector coprocessor: vsetvli, vsetvap and a strided, precision-truncating element load.
// Config ops finish in 2 cycles, loads in ~2*vl+2; mem_valid is held until mem_ready.
module picorv32_pcpi_vec
    import picorv32_pcpi_vec_pkg::*;
#(
    parameter int VLEN = VLEN_DEF,
    parameter int NREG = NREG_DEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        pcpi_valid,
    input  logic [31:0] pcpi_insn,
    input  logic [31:0] pcpi_cpurs1,
    input  logic [31:0] pcpi_cpurs2,
    output logic        pcpi_wr,
    output logic [31:0] pcpi_rd,
    output logic        pcpi_wait,
    output logic        pcpi_ready,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata
);
    localparam int          IW     = $clog2(VLEN/8);
    localparam int          RW     = $clog2(NREG);
    localparam logic [31:0] VLMAX8 = 32'(VLEN/8);

    state_e        r_state;
    op_e           r_op;
    sew_e          r_insn_sew, r_vtype;
    logic [RW-1:0] r_vd;
    logic [31:0]   r_rs1, r_rs2, r_vl, r_i, r_addr, r_rd, r_mem_addr;
    logic [5:0]    r_vap;
    logic [4:0]    r_elem_off;
    logic          r_skip, r_wr, r_wait, r_ready, r_mem_valid;

    logic        w_is_vsetvli, w_is_vsetvap, w_is_vles, w_dec_hit, w_trunc, w_we;
    op_e         w_dec_op;
    logic [31:0] w_new_vlmax, w_new_vl, w_vlmax, w_aaddr, w_shift, w_sew_mask, w_vap_mask;
    logic [31:0] w_elem, w_eidx;
    logic        w_unused;

    assign w_is_vsetvli = pcpi_insn[6:0] == OPC_OPV && pcpi_insn[14:12] == F3_VEC &&
                          !pcpi_insn[31] && pcpi_insn[24:22] <= 3'd2 && pcpi_insn[21:20] == 2'b00;
    assign w_is_vsetvap = pcpi_insn[6:0] == OPC_CUST && pcpi_insn[14:12] == F3_VEC &&
                          pcpi_insn[31:25] == F7_VSETVAP;
    assign w_is_vles    = pcpi_insn[6:0] == OPC_CUST && pcpi_insn[14:12] == F3_VEC &&
                          pcpi_insn[31:26] == F6_VLES_VARP && pcpi_insn[25];
    assign w_dec_hit    = w_is_vsetvli || w_is_vsetvap || w_is_vles;

    always_comb begin
        w_dec_op = OP_VLES;
        if (w_is_vsetvli)      w_dec_op = OP_VSETVLI;
        else if (w_is_vsetvap) w_dec_op = OP_VSETVAP;
    end

    assign w_new_vlmax = VLMAX8 >> r_insn_sew;
    assign w_new_vl    = (r_rs1 < w_new_vlmax) ? r_rs1 : w_new_vlmax;
    assign w_vlmax     = VLMAX8 >> r_vtype;

    // Wider elements are forced to natural alignment before picking the byte lane.
    always_comb begin
        w_aaddr    = r_addr;
        w_sew_mask = 32'hFFFF_FFFF;
        case (r_vtype)
            SEW_E8:  w_sew_mask = 32'h0000_00FF;
            SEW_E16: begin w_aaddr[0] = 1'b0; w_sew_mask = 32'h0000_FFFF; end
            default: w_aaddr[1:0] = 2'b00;
        endcase
    end

    assign w_shift    = mem_rdata >> {w_aaddr[1:0], 3'b000};
    assign w_trunc    = (r_vap != 6'd0) && (r_vap < sew_bits(r_vtype));
    assign w_vap_mask = (32'h1 << r_vap) - 32'h1;
    assign w_elem     = w_shift & w_sew_mask & (w_trunc ? w_vap_mask : 32'hFFFF_FFFF);
    assign w_eidx     = 32'(r_elem_off) + r_i;
    assign w_we       = (r_state == ST_LOAD_WAIT) && mem_ready && (w_eidx < w_vlmax);
    assign w_unused   = ^{pcpi_insn[19:15], w_eidx[31:IW]};

    pcpi_vec_regfile #(.VLEN(VLEN), .NREG(NREG)) u_rf (
        .clk    (clk),
        .resetn (resetn),
        .i_we   (w_we),
        .i_reg  (r_vd),
        .i_idx  (w_eidx[IW-1:0]),
        .i_sew  (r_vtype),
        .i_data (w_elem)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_VSETVLI;
            r_insn_sew  <= SEW_E8;
            r_vtype     <= SEW_E8;
            r_vd        <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_vl        <= '0;
            r_i         <= '0;
            r_addr      <= '0;
            r_rd        <= '0;
            r_mem_addr  <= '0;
            r_vap       <= '0;
            r_elem_off  <= '0;
            r_skip      <= 1'b0;
            r_wr        <= 1'b0;
            r_wait      <= 1'b0;
            r_ready     <= 1'b0;
            r_mem_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // The CPU still drives pcpi_valid in the cycle after ready.
                    r_skip <= 1'b0;
                    if (!r_skip && pcpi_valid && w_dec_hit) begin
                        r_op       <= w_dec_op;
                        r_vd       <= pcpi_insn[7 +: RW];
                        r_insn_sew <= sew_e'(pcpi_insn[23:22]);
                        r_rs1      <= pcpi_cpurs1;
                        r_rs2      <= pcpi_cpurs2;
                        r_wait     <= 1'b1;
                        r_state    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    case (r_op)
                        OP_VSETVLI: begin
                            r_vl    <= w_new_vl;
                            r_vtype <= r_insn_sew;
                            r_rd    <= w_new_vl;
                            r_wr    <= 1'b1;
                            r_ready <= 1'b1;
                            r_wait  <= 1'b0;
                            r_state <= ST_DONE;
                        end
                        OP_VSETVAP: begin
                            r_vap      <= r_rs1[5:0];
                            r_elem_off <= r_rs2[4:0];
                            r_ready    <= 1'b1;
                            r_wait     <= 1'b0;
                            r_state    <= ST_DONE;
                        end
                        default: begin
                            r_i    <= '0;
                            r_addr <= r_rs1;
                            if (r_vl == 32'd0) begin
                                r_ready <= 1'b1;
                                r_wait  <= 1'b0;
                                r_state <= ST_DONE;
                            end else begin
                                r_state <= ST_LOAD_REQ;
                            end
                        end
                    endcase
                end
                ST_LOAD_REQ: begin
                    r_mem_valid <= 1'b1;
                    r_mem_addr  <= {w_aaddr[31:2], 2'b00};
                    r_state     <= ST_LOAD_WAIT;
                end
                ST_LOAD_WAIT: begin
                    if (mem_ready) begin
                        r_mem_valid <= 1'b0;
                        r_i         <= r_i + 32'd1;
                        r_addr      <= r_addr + r_rs2;
                        if (r_i + 32'd1 == r_vl) begin
                            r_ready <= 1'b1;
                            r_wait  <= 1'b0;
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_LOAD_REQ;
                        end
                    end
                end
                default: begin
                    r_ready <= 1'b0;
                    r_wr    <= 1'b0;
                    r_skip  <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign pcpi_wr    = r_wr;
    assign pcpi_rd    = r_rd;
    assign pcpi_wait  = r_wait;
    assign pcpi_ready = r_ready;
    assign mem_valid  = r_mem_valid;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = 32'h0;
    assign mem_wstrb  = 4'h0;
endmodule

// File: tb/tb_picorv32_pcpi_vec.sv
// Bench for picorv32_pcpi_vec: scoreboarded PCPI results and memory addresses,
// with a word memory model that inserts random single-cycle ready delays.
module tb_picorv32_pcpi_vec;
    import picorv32_pcpi_vec_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn, pcpi_cpurs1, pcpi_cpurs2;
    logic        pcpi_wr, pcpi_wait, pcpi_ready;
    logic [31:0] pcpi_rd;
    logic        mem_valid, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    always #5 clk = ~clk;

    picorv32_pcpi_vec dut (
        .clk(clk), .resetn(resetn),
        .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
        .pcpi_cpurs1(pcpi_cpurs1), .pcpi_cpurs2(pcpi_cpurs2),
        .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd), .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
    );

    typedef struct packed {
        logic        wr;
        logic [31:0] rd;
    } res_t;

    logic [31:0] mem [0:255];
    logic [31:0] addr_q[$];
    res_t        res_q[$];
    logic [31:0] exp_addr;
    int          n_checks = 0;
    int          n_err    = 0;
    int          n_reads  = 0;
    int          wviol    = 0;
    int          pviol    = 0;
    bit          mem_hold = 1'b0;
    bit          delayed  = 1'b0;
    bit          prev_hs  = 1'b0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_vsetvli(input logic [4:0] zimm);
        return {1'b0, 6'b0, zimm, 5'd10, 3'b111, 5'd11, 7'b1010111};
    endfunction
    function automatic logic [31:0] enc_vsetvap();
        return {7'b1000000, 5'd12, 5'd10, 3'b111, 5'd0, 7'b1011011};
    endfunction
    function automatic logic [31:0] enc_vles(input logic [4:0] vd);
        return {2'b00, 4'b0001, 1'b1, 5'd12, 5'd10, 3'b111, vd, 7'b1011011};
    endfunction

    // Memory responder plus write-strobe and valid-drop protocol monitors.
    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_wstrb != 4'h0 || mem_wdata != 32'h0) wviol++;
            if (prev_hs && mem_valid) pviol++;
            if (mem_ready) begin
                mem_ready = 1'b0;
            end else if (mem_valid && resetn && !mem_hold) begin
                if (!delayed && $urandom_range(0, 1) == 1) begin
                    delayed = 1'b1;
                end else begin
                    delayed   = 1'b0;
                    mem_ready = 1'b1;
                    mem_rdata = mem[mem_addr[9:2]];
                    n_reads++;
                    if (addr_q.size() == 0) begin
                        check_eq("addr_unexpected", mem_addr, 32'hFFFF_FFFF);
                    end else begin
                        exp_addr = addr_q.pop_front();
                        check_eq("mem_addr", mem_addr, exp_addr);
                    end
                end
            end
            prev_hs = mem_valid && mem_ready;
        end
    end

    task automatic issue(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic exp_wr, input logic [31:0] exp_rd, input int bound);
        res_t r;
        int   lat;
        bit   done;
        r = {exp_wr, exp_rd};
        res_q.push_back(r);
        @(negedge clk);
        pcpi_insn   = insn;
        pcpi_cpurs1 = rs1;
        pcpi_cpurs2 = rs2;
        pcpi_valid  = 1'b1;
        lat  = 0;
        done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            lat++;
            if (lat == 1 && !pcpi_ready) check_eq("wait_after_accept", pcpi_wait, 1'b1);
            if (pcpi_ready) done = 1'b1;
        end
        check_eq("ready_seen", done, 1'b1);
        r = res_q.pop_front();
        if (done) begin
            check_eq("pcpi_wr", pcpi_wr, r.wr);
            if (r.wr) check_eq("pcpi_rd", pcpi_rd, r.rd);
            check_eq("latency_ok", lat <= bound, 1'b1);
        end
        @(negedge clk);
        check_eq("ready_one_cycle", pcpi_ready, 1'b0);
        @(negedge clk);
        check_eq("no_reaccept", pcpi_wait, 1'b0);
        pcpi_valid = 1'b0;
    endtask

    task automatic vles(input logic [4:0] vd, input logic [31:0] base, input logic [31:0] stride,
                        input int vl, input sew_e sew);
        logic [31:0] a;
        for (int i = 0; i < vl; i++) begin
            a = base + 32'(i) * stride;
            if (sew == SEW_E16) a[0] = 1'b0;
            if (sew == SEW_E32) a[1:0] = 2'b00;
            addr_q.push_back({a[31:2], 2'b00});
        end
        issue(enc_vles(vd), base, stride, 1'b0, 32'h0, 3 * vl + 3);
    endtask

    initial begin
        int  reads0;
        bit  seen;
        resetn      = 1'b0;
        pcpi_valid  = 1'b0;
        pcpi_insn   = '0;
        pcpi_cpurs1 = '0;
        pcpi_cpurs2 = '0;
        for (int k = 0; k < 256; k++) mem[k] = (32'(k) * 32'h0101_0101) ^ 32'hA5A5_A5A5;
        mem[100] = 32'h0403_0201;
        mem[101] = 32'h0807_0605;
        mem[104] = 32'h1413_1211;
        mem[105] = 32'hBEEF_CAFE;

        repeat (3) @(negedge clk);
        check_eq("rst_ready", pcpi_ready, 1'b0);
        check_eq("rst_wait",  pcpi_wait,  1'b0);
        check_eq("rst_wr",    pcpi_wr,    1'b0);
        check_eq("rst_rd",    pcpi_rd,    32'h0);
        check_eq("rst_mvalid", mem_valid, 1'b0);
        check_eq("rst_maddr", mem_addr,   32'h0);
        check_eq("rst_vl",    dut.r_vl,   32'h0);
        check_eq("rst_vtype", dut.r_vtype, SEW_E8);
        check_eq("rst_v1",    dut.u_rf.r_mem[1], 128'h0);
        resetn = 1'b1;

        issue(enc_vsetvli(5'h00), 32'd8,   32'd0, 1'b1, 32'd8,  3);
        issue(enc_vsetvli(5'h00), 32'd100, 32'd0, 1'b1, 32'd16, 3);
        issue(enc_vsetvli(5'h08), 32'd100, 32'd0, 1'b1, 32'd4,  3);
        issue(enc_vsetvli(5'h04), 32'd100, 32'd0, 1'b1, 32'd8,  3);

        issue(enc_vsetvap(), 32'd4, 32'd1, 1'b0, 32'h0, 3);
        check_eq("vap_set",     dut.r_vap,      6'd4);
        check_eq("elemoff_set", dut.r_elem_off, 5'd1);

        @(negedge clk);
        pcpi_insn  = 32'h0000_0033;
        pcpi_valid = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (pcpi_ready || pcpi_wait) seen = 1'b1;
        end
        pcpi_valid = 1'b0;
        check_eq("unrecognised_ignored", seen, 1'b0);

        issue(enc_vsetvap(), 32'd0, 32'd0, 1'b0, 32'h0, 3);
        issue(enc_vsetvli(5'h00), 32'd8, 32'd0, 1'b1, 32'd8, 3);
        vles(5'd1, 32'd400, 32'd1, 8, SEW_E8);
        check_eq("v1_e8", dut.u_rf.r_mem[1], 128'h0807_0605_0403_0201);

        issue(enc_vsetvli(5'h00), 32'd1, 32'd0, 1'b1, 32'd1, 3);
        vles(5'd2, 32'd419, 32'd1, 1, SEW_E8);
        issue(enc_vsetvap(), 32'd4, 32'd1, 1'b0, 32'h0, 3);
        issue(enc_vsetvli(5'h00), 32'd4, 32'd0, 1'b1, 32'd4, 3);
        vles(5'd2, 32'd416, 32'd1, 4, SEW_E8);
        check_eq("v2_vap4_off1", dut.u_rf.r_mem[2], 128'h04_0302_0114);

        issue(enc_vsetvap(), 32'd0, 32'd2, 1'b0, 32'h0, 3);
        issue(enc_vsetvli(5'h08), 32'd4, 32'd0, 1'b1, 32'd4, 3);
        vles(5'd3, 32'd402, 32'd4, 4, SEW_E32);
        check_eq("v3_e32_drop", dut.u_rf.r_mem[3], {mem[101], mem[100], 64'h0});

        issue(enc_vsetvap(), 32'd12, 32'd0, 1'b0, 32'h0, 3);
        issue(enc_vsetvli(5'h04), 32'd3, 32'd0, 1'b1, 32'd3, 3);
        vles(5'd4, 32'd418, 32'd2, 3, SEW_E16);
        check_eq("v4_e16_vap12", dut.u_rf.r_mem[4], 128'h0EEF_0AFE_0413);

        issue(enc_vsetvli(5'h00), 32'd0, 32'd0, 1'b1, 32'd0, 3);
        reads0 = n_reads;
        vles(5'd5, 32'd400, 32'd1, 0, SEW_E8);
        check_eq("vl0_no_reads", 32'(n_reads - reads0), 32'd0);
        check_eq("v5_untouched", dut.u_rf.r_mem[5], 128'h0);

        issue(enc_vsetvap(), 32'd0, 32'd0, 1'b0, 32'h0, 3);
        issue(enc_vsetvli(5'h00), 32'd8, 32'd0, 1'b1, 32'd8, 3);
        mem_hold = 1'b1;
        @(negedge clk);
        pcpi_insn   = enc_vles(5'd6);
        pcpi_cpurs1 = 32'd400;
        pcpi_cpurs2 = 32'd1;
        pcpi_valid  = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (mem_valid) seen = 1'b1;
        end
        check_eq("load_wait_reached", seen, 1'b1);
        resetn = 1'b0;
        #1;
        check_eq("abort_mvalid", mem_valid, 1'b0);
        check_eq("abort_wait",   pcpi_wait, 1'b0);
        check_eq("abort_state",  dut.r_state, ST_IDLE);
        pcpi_valid = 1'b0;
        mem_hold   = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        issue(enc_vsetvli(5'h00), 32'd100, 32'd0, 1'b1, 32'd16, 3);

        repeat (4) @(negedge clk);
        check_eq("wstrb_wdata_zero", 32'(wviol), 32'd0);
        check_eq("valid_drop_after_hs", 32'(pviol), 32'd0);
        check_eq("addr_q_drained", 32'(addr_q.size()), 32'd0);
        check_eq("res_q_drained",  32'(res_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule
